// File: rtl/rx_pkg.sv
// Shared UART receive/transmit definitions: FSM states, frame constants, tick divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rx_pkg;

    localparam int NB_BYTE    = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Clock cycles per oversample tick; integer truncation is intended so tx and rx agree.
    function automatic int tick_div(input int f_clock, input int baud_rate);
        return f_clock / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Free-running 16x oversample tick generator, cleared only by reset.
// Latency: o_tick high one cycle every TICK_DIV cycles, first at count TICK_DIV-1 after reset.
// Backpressure: none; the tick is a free-running strobe.
module rx_baud_tick #(
    parameter int F_CLOCK   = 25000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);
    import rx_pkg::*;

    localparam int TICK_DIV = tick_div(F_CLOCK, BAUD_RATE);
    localparam int NB_CNT   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TICK_DIV - 1);

    logic [NB_CNT-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + NB_CNT'(1);
        end
    end

    assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/rx_baudrate.sv
// UART 8N1 receiver assembling ceil(NB_DATA/8) LSB-first bytes into one word.
// Latency: o_valid one clock after the mid-stop-bit sample tick of the last byte.
// Backpressure: none; consumer must capture o_data on the o_valid pulse.
module rx_baudrate #(
    parameter int NB_DATA   = 16,
    parameter int F_CLOCK   = 25000000,
    parameter int BAUD_RATE = 9600,
    parameter int NB_BYTE   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_error
);
    import rx_pkg::*;

    localparam int NBYTES  = (NB_DATA + NB_BYTE - 1) / NB_BYTE;
    localparam int NB_K    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int NB_WORD = NBYTES * NB_BYTE;

    localparam logic [3:0]      S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]      B_LAST = 3'(NB_BYTE - 1);
    localparam logic [NB_K-1:0] K_LAST = NB_K'(NBYTES - 1);

    logic               tick;
    logic               sync_q1;
    logic               rx;
    rx_state_t          state, state_next;
    logic [3:0]         s_cnt, s_cnt_next;
    logic [2:0]         b_cnt, b_cnt_next;
    logic [NB_K-1:0]    k, k_next;
    logic [NB_BYTE-1:0] shreg, shreg_next;
    logic [NB_WORD-1:0] word, word_next, word_fill;
    logic [NB_DATA-1:0] data_next;
    logic               valid_next;
    logic               ferr_next;

    rx_baud_tick #(
        .F_CLOCK   (F_CLOCK),
        .BAUD_RATE (BAUD_RATE)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    // Current word with the just-received byte dropped into slot k.
    always_comb begin
        word_fill = word;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == NB_K'(i)) begin
                word_fill[i*NB_BYTE +: NB_BYTE] = shreg;
            end
        end
    end

    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        b_cnt_next = b_cnt;
        k_next     = k;
        shreg_next = shreg;
        word_next  = word;
        data_next  = o_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_MID) begin
                        if (!rx) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            b_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        shreg_next = {rx, shreg[NB_BYTE-1:1]};
                        s_cnt_next = '0;
                        if (b_cnt == B_LAST) begin
                            state_next = STOP;
                        end else begin
                            b_cnt_next = b_cnt + 3'd1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_next = '0;
                        if (rx) begin
                            word_next  = word_fill;
                            state_next = IDLE;
                            if (k == K_LAST) begin
                                data_next  = word_fill[NB_DATA-1:0];
                                valid_next = 1'b1;
                                k_next     = '0;
                            end else begin
                                k_next = k + NB_K'(1);
                            end
                        end else begin
                            // Bad stop bit: drop the partial word and wait out the low line.
                            ferr_next  = 1'b1;
                            k_next     = '0;
                            word_next  = '0;
                            state_next = BREAK;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q1       <= 1'b1;
            rx            <= 1'b1;
            state         <= IDLE;
            s_cnt         <= '0;
            b_cnt         <= '0;
            k             <= '0;
            shreg         <= '0;
            word          <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            sync_q1       <= i_data;
            rx            <= sync_q1;
            state         <= state_next;
            s_cnt         <= s_cnt_next;
            b_cnt         <= b_cnt_next;
            k             <= k_next;
            shreg         <= shreg_next;
            word          <= word_next;
            o_data        <= data_next;
            o_valid       <= valid_next;
            o_frame_error <= ferr_next;
        end
    end

endmodule

// File: tb/tb_rx_baudrate.sv
// Bench for rx_baudrate: a 9600-baud instance for default timing and a 115200-baud instance
// for the functional scenarios, both scored against expected-word queues.
module tb_rx_baudrate;
    import rx_pkg::*;

    localparam int D_DEF      = 162;
    localparam int BIT_DEF    = 2592;
    localparam int D_F        = 13;
    localparam int BIT_F_NOM  = 208;
    localparam int BIT_F_SLOW = 212;

    logic        clk = 1'b0;
    logic        rst_d, rst_f;
    logic        rxd_d, rxd_f;
    logic [15:0] data_d, data_f;
    logic        valid_d, valid_f;
    logic        ferr_d, ferr_f;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nvalid_d = 0, nvalid_f = 0;
    int nferr_d = 0, nferr_f = 0;
    int last_valid_cyc_d = 0;
    logic [15:0] q_d[$];
    logic [15:0] q_f[$];

    rx_baudrate #(
        .NB_DATA(16), .F_CLOCK(25000000), .BAUD_RATE(9600), .NB_BYTE(8)
    ) dut_def (
        .i_clk(clk), .i_reset(rst_d), .i_data(rxd_d),
        .o_data(data_d), .o_valid(valid_d), .o_frame_error(ferr_d)
    );

    rx_baudrate #(
        .NB_DATA(16), .F_CLOCK(25000000), .BAUD_RATE(115200), .NB_BYTE(8)
    ) dut_fast (
        .i_clk(clk), .i_reset(rst_f), .i_data(rxd_f),
        .o_data(data_f), .o_valid(valid_f), .o_frame_error(ferr_f)
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Scoreboard monitors, sampling on the falling edge.
    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (valid_f || ferr_f) begin
                checks++;
                if (valid_f && ferr_f) begin
                    failures++;
                    $display("FAIL fast_exclusive valid=%b ferr=%b required not both high", valid_f, ferr_f);
                end
            end
            if (ferr_f) nferr_f++;
            if (valid_f) begin
                nvalid_f++;
                checks++;
                if (q_f.size() == 0) begin
                    failures++;
                    $display("FAIL fast_unexpected_valid data=%h required no valid", data_f);
                end else begin
                    exp_w = q_f.pop_front();
                    if (data_f !== exp_w) begin
                        failures++;
                        $display("FAIL fast_word data=%h required=%h", data_f, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (valid_d || ferr_d) begin
                checks++;
                if (valid_d && ferr_d) begin
                    failures++;
                    $display("FAIL def_exclusive valid=%b ferr=%b required not both high", valid_d, ferr_d);
                end
            end
            if (ferr_d) nferr_d++;
            if (valid_d) begin
                nvalid_d++;
                last_valid_cyc_d = cyc;
                checks++;
                if (q_d.size() == 0) begin
                    failures++;
                    $display("FAIL def_unexpected_valid data=%h required no valid", data_d);
                end else begin
                    exp_w = q_d.pop_front();
                    if (data_d !== exp_w) begin
                        failures++;
                        $display("FAIL def_word data=%h required=%h", data_d, exp_w);
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel_fast, input logic v);
        if (sel_fast) rxd_f = v;
        else          rxd_d = v;
    endtask

    // Sends start, 8 data bits LSB first and the given stop bit; nbits<10 truncates the frame.
    task automatic send_frame(input bit sel_fast, input logic [7:0] b, input logic stop,
                              input int bitclk, input int nbits);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive(sel_fast, fr[i]);
            wait_clks(bitclk);
        end
    endtask

    task automatic test_reset();
        rst_d = 1'b1; rst_f = 1'b1;
        wait_clks(4);
        rst_d = 1'b0; rst_f = 1'b0;
        wait_clks(2);
        checks += 7;
        if (data_d !== 16'h0000) begin failures++; $display("FAIL reset_def_data data=%h required=0000", data_d); end
        if (valid_d !== 1'b0)    begin failures++; $display("FAIL reset_def_valid valid=%b required=0", valid_d); end
        if (ferr_d !== 1'b0)     begin failures++; $display("FAIL reset_def_ferr ferr=%b required=0", ferr_d); end
        if (data_f !== 16'h0000) begin failures++; $display("FAIL reset_fast_data data=%h required=0000", data_f); end
        if (valid_f !== 1'b0)    begin failures++; $display("FAIL reset_fast_valid valid=%b required=0", valid_f); end
        if (ferr_f !== 1'b0)     begin failures++; $display("FAIL reset_fast_ferr ferr=%b required=0", ferr_f); end
        if (dut_fast.state !== IDLE) begin failures++; $display("FAIL reset_fast_state state=%0d required=%0d", dut_fast.state, IDLE); end
    endtask

    task automatic test_default_rate();
        int start_cyc;
        int lo, hi;
        send_frame(1'b0, 8'hA5, 1'b1, BIT_DEF, 10);
        q_d.push_back(16'h3CA5);
        start_cyc = cyc;
        send_frame(1'b0, 8'h3C, 1'b1, BIT_DEF, 10);
        wait_clks(BIT_DEF);
        lo = start_cyc + 151 * D_DEF;
        hi = start_cyc + 152 * D_DEF + 5;
        checks += 5;
        if (nvalid_d !== 1) begin failures++; $display("FAIL def_valid_count count=%0d required=1", nvalid_d); end
        if (q_d.size() !== 0) begin failures++; $display("FAIL def_drain pending=%0d required=0", q_d.size()); end
        if (nferr_d !== 0) begin failures++; $display("FAIL def_ferr_count count=%0d required=0", nferr_d); end
        if (data_d !== 16'h3CA5) begin failures++; $display("FAIL def_hold data=%h required=3ca5", data_d); end
        if (last_valid_cyc_d < lo || last_valid_cyc_d > hi) begin
            failures++;
            $display("FAIL def_latency cycle=%0d required=%0d..%0d", last_valid_cyc_d, lo, hi);
        end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = nvalid_f; e0 = nferr_f;
        drive(1'b1, 1'b0);
        wait_clks(4 * D_F);
        drive(1'b1, 1'b1);
        wait_clks(3 * BIT_F_NOM);
        checks += 3;
        if (nvalid_f !== v0) begin failures++; $display("FAIL glitch_valid count=%0d required=%0d", nvalid_f, v0); end
        if (nferr_f !== e0)  begin failures++; $display("FAIL glitch_ferr count=%0d required=%0d", nferr_f, e0); end
        if (dut_fast.state !== IDLE) begin failures++; $display("FAIL glitch_state state=%0d required=%0d", dut_fast.state, IDLE); end
        send_frame(1'b1, 8'h11, 1'b1, BIT_F_NOM, 10);
        q_f.push_back(16'h2211);
        send_frame(1'b1, 8'h22, 1'b1, BIT_F_NOM, 10);
        wait_clks(2 * BIT_F_NOM);
        checks += 2;
        if (nvalid_f !== v0 + 1) begin failures++; $display("FAIL glitch_word_count count=%0d required=%0d", nvalid_f, v0 + 1); end
        if (q_f.size() !== 0) begin failures++; $display("FAIL glitch_drain pending=%0d required=0", q_f.size()); end
    endtask

    task automatic test_frame_error();
        int v0, e0;
        v0 = nvalid_f; e0 = nferr_f;
        send_frame(1'b1, 8'h55, 1'b1, BIT_F_NOM, 10);
        send_frame(1'b1, 8'hFF, 1'b0, BIT_F_NOM, 10);
        wait_clks(3 * BIT_F_NOM);
        drive(1'b1, 1'b1);
        wait_clks(2 * BIT_F_NOM);
        checks += 2;
        if (nferr_f !== e0 + 1) begin failures++; $display("FAIL ferr_count count=%0d required=%0d", nferr_f, e0 + 1); end
        if (nvalid_f !== v0) begin failures++; $display("FAIL ferr_no_valid count=%0d required=%0d", nvalid_f, v0); end
        send_frame(1'b1, 8'h34, 1'b1, BIT_F_NOM, 10);
        q_f.push_back(16'h1234);
        send_frame(1'b1, 8'h12, 1'b1, BIT_F_NOM, 10);
        wait_clks(2 * BIT_F_NOM);
        checks += 3;
        if (nvalid_f !== v0 + 1) begin failures++; $display("FAIL ferr_recover_count count=%0d required=%0d", nvalid_f, v0 + 1); end
        if (q_f.size() !== 0) begin failures++; $display("FAIL ferr_drain pending=%0d required=0", q_f.size()); end
        if (nferr_f !== e0 + 1) begin failures++; $display("FAIL ferr_single count=%0d required=%0d", nferr_f, e0 + 1); end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        v0 = nvalid_f; e0 = nferr_f;
        send_frame(1'b1, 8'hAB, 1'b1, BIT_F_NOM, 10);
        send_frame(1'b1, 8'h00, 1'b1, BIT_F_NOM, 5);
        rst_f = 1'b1;
        drive(1'b1, 1'b1);
        wait_clks(1);
        rst_f = 1'b0;
        checks += 2;
        if (data_f !== 16'h0000) begin failures++; $display("FAIL midreset_data data=%h required=0000", data_f); end
        if (dut_fast.state !== IDLE) begin failures++; $display("FAIL midreset_state state=%0d required=%0d", dut_fast.state, IDLE); end
        wait_clks(2 * BIT_F_NOM);
        send_frame(1'b1, 8'hCD, 1'b1, BIT_F_NOM, 10);
        q_f.push_back(16'hEFCD);
        send_frame(1'b1, 8'hEF, 1'b1, BIT_F_NOM, 10);
        wait_clks(2 * BIT_F_NOM);
        checks += 3;
        if (nvalid_f !== v0 + 1) begin failures++; $display("FAIL midreset_count count=%0d required=%0d", nvalid_f, v0 + 1); end
        if (nferr_f !== e0) begin failures++; $display("FAIL midreset_ferr count=%0d required=%0d", nferr_f, e0); end
        if (q_f.size() !== 0) begin failures++; $display("FAIL midreset_drain pending=%0d required=0", q_f.size()); end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [7:0] bytes [4];
        v0 = nvalid_f;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
        q_f.push_back(16'h0201);
        q_f.push_back(16'h0403);
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b1, bytes[i], 1'b1, BIT_F_NOM, 10);
        end
        wait_clks(2 * BIT_F_NOM);
        checks += 2;
        if (nvalid_f !== v0 + 2) begin failures++; $display("FAIL b2b_count count=%0d required=%0d", nvalid_f, v0 + 2); end
        if (q_f.size() !== 0) begin failures++; $display("FAIL b2b_drain pending=%0d required=0", q_f.size()); end
    endtask

    task automatic test_baud_tolerance();
        int v0;
        v0 = nvalid_f;
        send_frame(1'b1, 8'h5A, 1'b1, BIT_F_SLOW, 10);
        q_f.push_back(16'hC35A);
        send_frame(1'b1, 8'hC3, 1'b1, BIT_F_SLOW, 10);
        wait_clks(2 * BIT_F_SLOW);
        checks += 3;
        if (nvalid_f !== v0 + 1) begin failures++; $display("FAIL slow_count count=%0d required=%0d", nvalid_f, v0 + 1); end
        if (q_f.size() !== 0) begin failures++; $display("FAIL slow_drain pending=%0d required=0", q_f.size()); end
        if (data_f !== 16'hC35A) begin failures++; $display("FAIL slow_hold data=%h required=c35a", data_f); end
    endtask

    initial begin
        rxd_d = 1'b1;
        rxd_f = 1'b1;
        rst_d = 1'b1;
        rst_f = 1'b1;
        test_reset();
        fork
            test_default_rate();
            begin
                test_glitch();
                test_frame_error();
                test_reset_mid();
                test_back_to_back();
                test_baud_tolerance();
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
